// File: rtl/vx_dcache_req_pkg.sv
// Shared request bundle layout and sizing helpers for the data-cache request buffer.
package vx_dcache_req_pkg;

   localparam int unsigned DCACHE_WORD_SIZE  = 4;
   localparam int unsigned DCACHE_WORD_WIDTH = 8 * DCACHE_WORD_SIZE;
   localparam int unsigned DCACHE_ADDR_WIDTH = 30;
   localparam int unsigned DCACHE_TAG_WIDTH  = 8;
   localparam int unsigned DCACHE_MOD_BITS   = 3;

   typedef struct packed {
      logic                         rw;
      logic [DCACHE_MOD_BITS-1:0]   op_mod;
      logic                         is_amo;
      logic [DCACHE_WORD_SIZE-1:0]  byteen;
      logic [DCACHE_ADDR_WIDTH-1:0] addr;
      logic [DCACHE_WORD_WIDTH-1:0] data;
      logic [DCACHE_TAG_WIDTH-1:0]  tag;
   } dcache_req_t;

   // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/vx_dcache_req_lane_fifo.sv
// One request lane: DEPTH-entry FIFO with count, wrap-around pointers and
// an optional block that holds off new requests behind a buffered atomic.
module vx_dcache_req_lane_fifo
   import vx_dcache_req_pkg::*;
#(
   parameter int unsigned WORD_SIZE     = 4,
   parameter int unsigned ADDR_WIDTH    = 30,
   parameter int unsigned TAG_WIDTH     = 8,
   parameter int unsigned MOD_BITS      = 3,
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned AMO_SERIALIZE = 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   input  logic                           in_rw,
   input  logic                           in_is_amo,
   input  logic [MOD_BITS-1:0]            in_op_mod,
   input  logic [WORD_SIZE-1:0]           in_byteen,
   input  logic [ADDR_WIDTH-1:0]          in_addr,
   input  logic [8*WORD_SIZE-1:0]         in_data,
   input  logic [TAG_WIDTH-1:0]           in_tag,
   output logic                           in_ready,
   output logic                           out_valid,
   output logic                           out_rw,
   output logic                           out_is_amo,
   output logic [MOD_BITS-1:0]            out_op_mod,
   output logic [WORD_SIZE-1:0]           out_byteen,
   output logic [ADDR_WIDTH-1:0]          out_addr,
   output logic [8*WORD_SIZE-1:0]         out_data,
   output logic [TAG_WIDTH-1:0]           out_tag,
   input  logic                           out_ready,
   output logic [occ_width(DEPTH)-1:0]    occupancy,
   output logic                           empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = occ_width(DEPTH);

   typedef struct packed {
      logic                   rw;
      logic [MOD_BITS-1:0]    op_mod;
      logic                   is_amo;
      logic [WORD_SIZE-1:0]   byteen;
      logic [ADDR_WIDTH-1:0]  addr;
      logic [8*WORD_SIZE-1:0] data;
      logic [TAG_WIDTH-1:0]   tag;
   } lane_req_t;

   lane_req_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W-1:0] r_amo_ptr;
   logic [OCC_W-1:0] r_count;
   logic             r_amo_block;

   logic             w_enq;
   logic             w_deq;
   logic             w_amo_done;
   lane_req_t        w_in_req;
   lane_req_t        w_head;

   assign w_in_req = '{rw: in_rw, op_mod: in_op_mod, is_amo: in_is_amo, byteen: in_byteen,
                       addr: in_addr, data: in_data, tag: in_tag};

   assign in_ready   = (r_count != OCC_W'(DEPTH)) && !r_amo_block;
   assign out_valid  = (r_count != '0);
   assign w_enq      = in_valid && in_ready;
   assign w_deq      = out_valid && out_ready;
   // The blocking AMO is recognised by the slot it was written to, not by the head's is_amo bit.
   assign w_amo_done = r_amo_block && w_deq && (r_rptr == r_amo_ptr);

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wptr] <= w_in_req;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_amo_ptr   <= '0;
         r_count     <= '0;
         r_amo_block <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + OCC_W'(1);
         end else if (w_deq && !w_enq) begin
            r_count <= r_count - OCC_W'(1);
         end
         if (AMO_SERIALIZE != 0) begin
            if (w_enq && in_is_amo) begin
               r_amo_block <= 1'b1;
               r_amo_ptr   <= r_wptr;
            end else if (w_amo_done) begin
               r_amo_block <= 1'b0;
            end
         end
      end
   end

   assign w_head     = r_mem[r_rptr];
   assign out_rw     = w_head.rw;
   assign out_is_amo = w_head.is_amo;
   assign out_op_mod = w_head.op_mod;
   assign out_byteen = w_head.byteen;
   assign out_addr   = w_head.addr;
   assign out_data   = w_head.data;
   assign out_tag    = w_head.tag;
   assign occupancy  = r_count;
   assign empty      = (r_count == '0) && !r_amo_block;

   a_hold_stable : assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(w_head)));

endmodule

// File: rtl/vx_dcache_req_buffer.sv
// Per-lane elastic buffer between the LSU request port and the data-cache core port.
// Lanes are independent; all_empty feeds fence logic.
module vx_dcache_req_buffer
   import vx_dcache_req_pkg::*;
#(
   parameter int unsigned NUM_REQS      = 4,
   parameter int unsigned WORD_SIZE     = 4,
   parameter int unsigned ADDR_WIDTH    = 30,
   parameter int unsigned TAG_WIDTH     = 8,
   parameter int unsigned MOD_BITS      = 3,
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned AMO_SERIALIZE = 1
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic [NUM_REQS-1:0]                         in_valid,
   input  logic [NUM_REQS-1:0]                         in_rw,
   input  logic [NUM_REQS-1:0]                         in_is_amo,
   input  logic [NUM_REQS-1:0][MOD_BITS-1:0]           in_op_mod,
   input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]          in_byteen,
   input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]         in_addr,
   input  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0]        in_data,
   input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]          in_tag,
   output logic [NUM_REQS-1:0]                         in_ready,
   output logic [NUM_REQS-1:0]                         out_valid,
   output logic [NUM_REQS-1:0]                         out_rw,
   output logic [NUM_REQS-1:0]                         out_is_amo,
   output logic [NUM_REQS-1:0][MOD_BITS-1:0]           out_op_mod,
   output logic [NUM_REQS-1:0][WORD_SIZE-1:0]          out_byteen,
   output logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]         out_addr,
   output logic [NUM_REQS-1:0][8*WORD_SIZE-1:0]        out_data,
   output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]          out_tag,
   input  logic [NUM_REQS-1:0]                         out_ready,
   output logic [NUM_REQS-1:0][occ_width(DEPTH)-1:0]   occupancy,
   output logic                                        all_empty
);

   logic [NUM_REQS-1:0] w_empty;

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
      vx_dcache_req_lane_fifo #(
         .WORD_SIZE     (WORD_SIZE),
         .ADDR_WIDTH    (ADDR_WIDTH),
         .TAG_WIDTH     (TAG_WIDTH),
         .MOD_BITS      (MOD_BITS),
         .DEPTH         (DEPTH),
         .AMO_SERIALIZE (AMO_SERIALIZE)
      ) u_lane (
         .clk        (clk),
         .reset_n    (reset_n),
         .in_valid   (in_valid[g]),
         .in_rw      (in_rw[g]),
         .in_is_amo  (in_is_amo[g]),
         .in_op_mod  (in_op_mod[g]),
         .in_byteen  (in_byteen[g]),
         .in_addr    (in_addr[g]),
         .in_data    (in_data[g]),
         .in_tag     (in_tag[g]),
         .in_ready   (in_ready[g]),
         .out_valid  (out_valid[g]),
         .out_rw     (out_rw[g]),
         .out_is_amo (out_is_amo[g]),
         .out_op_mod (out_op_mod[g]),
         .out_byteen (out_byteen[g]),
         .out_addr   (out_addr[g]),
         .out_data   (out_data[g]),
         .out_tag    (out_tag[g]),
         .out_ready  (out_ready[g]),
         .occupancy  (occupancy[g]),
         .empty      (w_empty[g])
      );
   end

   assign all_empty = &w_empty;

endmodule

// File: tb/tb_vx_dcache_req_buffer.sv
// Bench for vx_dcache_req_buffer: a serialising DEPTH=2 instance and a non-serialising
// DEPTH=4 instance share stimulus and are compared every cycle against a queue model.
module tb_vx_dcache_req_buffer;

   localparam int NR = 4;
   localparam int MB = 3;
   localparam int WS = 4;
   localparam int AW = 30;
   localparam int TW = 8;
   localparam int WW = 32;

   typedef struct packed {
      logic          rw;
      logic [MB-1:0] mod;
      logic          amo;
      logic [WS-1:0] be;
      logic [AW-1:0] addr;
      logic [WW-1:0] data;
      logic [TW-1:0] tag;
   } req_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic [NR-1:0]         in_valid, in_rw, in_is_amo, out_ready;
   logic [NR-1:0][MB-1:0] in_op_mod;
   logic [NR-1:0][WS-1:0] in_byteen;
   logic [NR-1:0][AW-1:0] in_addr;
   logic [NR-1:0][WW-1:0] in_data;
   logic [NR-1:0][TW-1:0] in_tag;

   logic [NR-1:0]         o_ready [2];
   logic [NR-1:0]         o_valid [2];
   logic [NR-1:0]         o_rw    [2];
   logic [NR-1:0]         o_amo   [2];
   logic [NR-1:0][MB-1:0] o_mod   [2];
   logic [NR-1:0][WS-1:0] o_be    [2];
   logic [NR-1:0][AW-1:0] o_addr  [2];
   logic [NR-1:0][WW-1:0] o_data  [2];
   logic [NR-1:0][TW-1:0] o_tag   [2];
   logic [NR-1:0][1:0]    occ0;
   logic [NR-1:0][2:0]    occ1;
   logic [1:0]            o_empty;

   always #5 clk = ~clk;

   vx_dcache_req_buffer #(
      .NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MOD_BITS(MB),
      .DEPTH(2), .AMO_SERIALIZE(1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_rw(in_rw), .in_is_amo(in_is_amo), .in_op_mod(in_op_mod),
      .in_byteen(in_byteen), .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag),
      .in_ready(o_ready[0]),
      .out_valid(o_valid[0]), .out_rw(o_rw[0]), .out_is_amo(o_amo[0]), .out_op_mod(o_mod[0]),
      .out_byteen(o_be[0]), .out_addr(o_addr[0]), .out_data(o_data[0]), .out_tag(o_tag[0]),
      .out_ready(out_ready), .occupancy(occ0), .all_empty(o_empty[0])
   );

   vx_dcache_req_buffer #(
      .NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MOD_BITS(MB),
      .DEPTH(4), .AMO_SERIALIZE(0)
   ) dut_noser (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_rw(in_rw), .in_is_amo(in_is_amo), .in_op_mod(in_op_mod),
      .in_byteen(in_byteen), .in_addr(in_addr), .in_data(in_data), .in_tag(in_tag),
      .in_ready(o_ready[1]),
      .out_valid(o_valid[1]), .out_rw(o_rw[1]), .out_is_amo(o_amo[1]), .out_op_mod(o_mod[1]),
      .out_byteen(o_be[1]), .out_addr(o_addr[1]), .out_data(o_data[1]), .out_tag(o_tag[1]),
      .out_ready(out_ready), .occupancy(occ1), .all_empty(o_empty[1])
   );

   // Model: one request queue per (instance, lane); index k = d*NR + lane.
   req_t mq [2*NR][$];
   bit   exp_rdy [2*NR];
   bit   exp_val [2*NR];
   int   deq_cnt [2*NR];
   int   vectors = 0;
   int   errors  = 0;

   function automatic int depth_of(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   function automatic bit ser_of(input int d);
      return (d == 0);
   endfunction

   function automatic bit has_amo(input int k);
      for (int i = 0; i < mq[k].size(); i++) begin
         if (mq[k][i].amo) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int occ_of(input int d, input int l);
      return (d == 0) ? int'(occ0[l]) : int'(occ1[l]);
   endfunction

   function automatic req_t head_of(input int d, input int l);
      return req_t'({o_rw[d][l], o_mod[d][l], o_amo[d][l], o_be[d][l],
                     o_addr[d][l], o_data[d][l], o_tag[d][l]});
   endfunction

   function automatic req_t in_req(input int l);
      return req_t'({in_rw[l], in_op_mod[l], in_is_amo[l], in_byteen[l],
                     in_addr[l], in_data[l], in_tag[l]});
   endfunction

   task automatic chk(input string name, input int lane, input logic [127:0] act,
                      input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane %0d: got %0h, expected %0h", name, lane, act, exp);
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 2; d++) begin
         bit all_mt;
         all_mt = 1'b1;
         for (int l = 0; l < NR; l++) begin
            int k;
            k = d * NR + l;
            exp_val[k] = (mq[k].size() != 0);
            exp_rdy[k] = (mq[k].size() < depth_of(d)) && !(ser_of(d) && has_amo(k));
            if (exp_val[k]) all_mt = 1'b0;
            chk("in_ready", k, o_ready[d][l], exp_rdy[k]);
            chk("out_valid", k, o_valid[d][l], exp_val[k]);
            chk("occupancy", k, occ_of(d, l), mq[k].size());
            if (exp_val[k]) chk("head", k, head_of(d, l), mq[k][0]);
         end
         chk("all_empty", d, o_empty[d], all_mt);
      end
   endtask

   task automatic update_model();
      for (int d = 0; d < 2; d++) begin
         for (int l = 0; l < NR; l++) begin
            int k;
            k = d * NR + l;
            if (!reset_n) begin
               mq[k].delete();
            end else begin
               if (exp_val[k] && out_ready[l]) begin
                  void'(mq[k].pop_front());
                  deq_cnt[k]++;
               end
               if (in_valid[l] && exp_rdy[k]) mq[k].push_back(in_req(l));
            end
         end
      end
   endtask

   // Called at a negedge with inputs set; returns at the next negedge.
   task automatic cycle();
      #1;
      check_model();
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   task automatic set_idle();
      in_valid  = '0;
      in_rw     = '0;
      in_is_amo = '0;
      in_op_mod = '0;
      in_byteen = '0;
      in_addr   = '0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = '0;
   endtask

   task automatic rand_payload(input int l);
      in_rw[l]     = 1'($urandom_range(0, 1));
      in_op_mod[l] = MB'($urandom);
      in_byteen[l] = WS'($urandom);
      in_addr[l]   = AW'($urandom);
      in_data[l]   = $urandom;
      in_tag[l]    = TW'($urandom);
   endtask

   task automatic drive_rand(input int unsigned pv, input int unsigned pr, input int unsigned pa);
      for (int l = 0; l < NR; l++) begin
         rand_payload(l);
         in_valid[l]  = ($urandom_range(0, 99) < pv);
         out_ready[l] = ($urandom_range(0, 99) < pr);
         in_is_amo[l] = ($urandom_range(0, 99) < pa);
      end
   endtask

   task automatic drain();
      set_idle();
      out_ready = '1;
      repeat (5) cycle();
   endtask

   task automatic clear_counts();
      for (int k = 0; k < 2 * NR; k++) deq_cnt[k] = 0;
   endtask

   initial begin
      set_idle();
      clear_counts();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      for (int l = 0; l < NR; l++) begin
         chk("rst_ready", l, o_ready[0][l], 1'b1);
         chk("rst_valid", l, o_valid[0][l], 1'b0);
         chk("rst_occ", l, occ0[l], 0);
      end
      chk("rst_all_empty", 0, o_empty[0], 1'b1);
      reset_n = 1'b1;
      @(negedge clk);

      // Single lane ordering and full-lane refusal
      in_valid[0] = 1'b1;
      in_addr[0]  = 30'h10;
      in_tag[0]   = 8'h01;
      cycle();
      chk("t1_valid", 0, o_valid[0][0], 1'b1);
      chk("t1_occ1", 0, occ0[0], 1);
      chk("t1_addr", 0, o_addr[0][0], 30'h10);
      in_addr[0] = 30'h14;
      in_tag[0]  = 8'h02;
      cycle();
      chk("t1_full_ready", 0, o_ready[0][0], 1'b0);
      chk("t1_occ2", 0, occ0[0], 2);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      chk("t1_head0", 0, o_addr[0][0], 30'h10);
      cycle();
      chk("t1_head1", 0, o_addr[0][0], 30'h14);
      chk("t1_occ_after", 0, occ0[0], 1);
      cycle();
      chk("t1_drained", 0, o_valid[0][0], 1'b0);

      // Streaming at full rate on all lanes
      drain();
      clear_counts();
      set_idle();
      in_valid  = '1;
      out_ready = '1;
      for (int c = 0; c < 100; c++) begin
         for (int l = 0; l < NR; l++) begin
            in_addr[l]   = AW'(l * 256 + c);
            in_tag[l]    = TW'(c);
            in_data[l]   = $urandom;
            in_byteen[l] = '1;
         end
         cycle();
         for (int l = 0; l < NR; l++) chk("stream_occ_le1", l, occ0[l] <= 1, 1'b1);
      end
      in_valid = '0;
      cycle();
      for (int l = 0; l < NR; l++) chk("stream_count", l, deq_cnt[l], 100);

      // AMO serialisation on lane 0 while lane 1 streams
      drain();
      set_idle();
      in_valid[1]  = 1'b1;
      out_ready[1] = 1'b1;
      in_valid[0]  = 1'b1;
      in_rw[0]     = 1'b1;
      in_tag[0]    = 8'h11;
      cycle();
      in_is_amo[0] = 1'b1;
      in_tag[0]    = 8'h5A;
      cycle();
      chk("amo_block_ready", 0, o_ready[0][0], 1'b0);
      chk("amo_occ2", 0, occ0[0], 2);
      in_is_amo[0] = 1'b0;
      in_rw[0]     = 1'b0;
      in_tag[0]    = 8'h33;
      out_ready[0] = 1'b1;
      cycle();
      chk("amo_head_tag", 0, o_tag[0][0], 8'h5A);
      chk("amo_still_blocked", 0, o_ready[0][0], 1'b0);
      cycle();
      chk("amo_released", 0, o_ready[0][0], 1'b1);
      chk("amo_occ0", 0, occ0[0], 0);
      cycle();
      chk("load_tag", 0, o_tag[0][0], 8'h33);
      chk("lane1_ready", 1, o_ready[0][1], 1'b1);

      // Back-to-back AMOs with no serialisation
      drain();
      set_idle();
      in_valid  = '1;
      for (int c = 0; c < 4; c++) begin
         for (int l = 0; l < NR; l++) rand_payload(l);
         in_is_amo = '1;
         cycle();
      end
      for (int l = 0; l < NR; l++) begin
         chk("noser_occ4", l, occ1[l], 4);
         chk("ser_occ1", l, occ0[l], 1);
      end

      // Lane independence under a single stalled lane
      drain();
      clear_counts();
      set_idle();
      in_valid  = '1;
      out_ready = 4'b1011;
      repeat (20) begin
         for (int l = 0; l < NR; l++) rand_payload(l);
         cycle();
      end
      chk("indep_occ", 2, occ0[2], 2);
      chk("indep_ready", 2, o_ready[0][2], 1'b0);
      chk("indep_all_empty", 0, o_empty[0], 1'b0);
      chk("indep_flow", 0, deq_cnt[0] >= 18, 1'b1);
      chk("indep_flow", 1, deq_cnt[1] >= 18, 1'b1);
      chk("indep_flow", 3, deq_cnt[3] >= 18, 1'b1);

      // Reset mid-burst discards everything
      reset_n = 1'b0;
      for (int k = 0; k < 2 * NR; k++) mq[k].delete();
      #1;
      for (int l = 0; l < NR; l++) begin
         chk("rst2_valid", l, o_valid[0][l], 1'b0);
         chk("rst2_ready", l, o_ready[0][l], 1'b1);
         chk("rst2_occ", l, occ0[l], 0);
      end
      chk("rst2_all_empty", 0, o_empty[0], 1'b1);
      chk("rst2_all_empty", 1, o_empty[1], 1'b1);
      cycle();
      reset_n  = 1'b1;
      in_valid = '0;
      cycle();
      for (int l = 0; l < NR; l++) chk("post_rst_valid", l, o_valid[0][l], 1'b0);

      // Randomised traffic under several biases
      repeat (500) begin drive_rand(50, 50, 10); cycle(); end
      repeat (500) begin drive_rand(90, 30, 20); cycle(); end
      repeat (500) begin drive_rand(30, 90, 5);  cycle(); end
      repeat (500) begin drive_rand(80, 80, 30); cycle(); end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/vx_dcache_req_buffer.md
# vx_dcache_req_buffer

Parametrised per-lane elastic buffer for data-cache requests, placed between the LSU request port and the data-cache core-request port. Each of NUM_REQS lanes gets an independent DEPTH-entry FIFO carrying the full request bundle: valid, rw, op_mod, is_amo, byteen, addr, data and tag. A lane stall therefore never back-pressures the other lanes. Optional AMO serialisation blocks a lane behind an outstanding atomic, and occupancy/empty status supports fence logic.

## Interface
Parameters:
- NUM_REQS, 4, number of independent request lanes (>=1)
- WORD_SIZE, 4, bytes per word; WORD_WIDTH = 8*WORD_SIZE
- ADDR_WIDTH, 30, word-address width
- TAG_WIDTH, 8, request tag width
- MOD_BITS, 3, op_mod width
- DEPTH, 2, entries per lane; power of two, >=2
- AMO_SERIALIZE, 1, 1 = lane refuses new requests while an accepted AMO is still buffered

Ports (all per-lane buses packed [NUM_REQS-1:0][field]):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_REQS  upstream request valid
- in_rw / in_is_amo  in  NUM_REQS  write flag / atomic flag
- in_op_mod  in  NUM_REQS*MOD_BITS  instruction modifier
- in_byteen  in  NUM_REQS*WORD_SIZE  byte enables
- in_addr  in  NUM_REQS*ADDR_WIDTH  word address
- in_data  in  NUM_REQS*WORD_WIDTH  write data
- in_tag  in  NUM_REQS*TAG_WIDTH  tag
- in_ready  out  NUM_REQS  lane accepts
- out_valid, out_rw, out_is_amo, out_op_mod, out_byteen, out_addr, out_data, out_tag  out  same widths as inputs  downstream request
- out_ready  in  NUM_REQS  cache accepts
- occupancy  out  NUM_REQS*$clog2(DEPTH+1)  entries held per lane
- all_empty  out  1  every lane empty and no AMO block set

## Operation
- Enqueue on lane i: in_valid[i] && in_ready[i]. Dequeue on lane i: out_valid[i] && out_ready[i].
- in_ready[i] = (count[i] != DEPTH) && !amo_block[i]. There is no same-cycle dequeue lookahead: a full lane refuses even if it dequeues that cycle.
- out_valid[i] = (count[i] != 0). out_* fields come from the head entry, registered storage only, with no combinational path from in_* to out_*.
- count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- AMO_SERIALIZE=1:
  - Accepting an is_amo request sets amo_block[i].
  - amo_block[i] clears in the cycle that AMO entry is dequeued. Identify it by tracking its write pointer, not by head is_amo.
  - Non-AMO entries queued ahead of the AMO drain normally.
- AMO_SERIALIZE=0: amo_block is tied 0 and is_amo is only carried through.
- Lanes are fully independent; no cross-lane ordering is imposed.
- Payload bits of invalid or empty entries are don't-care. The verifier checks fields only when out_valid is high.

## Timing
- Minimum latency is 1 cycle: a request enqueued into an empty lane at edge N is out_valid after edge N.
- Throughput is 1 request/cycle/lane when DEPTH>=2 and out_ready is held high.
- An AMO blocks its lane from acceptance until the cycle after its dequeue edge. in_ready reasserts combinationally from the cleared flag.
- Reset (async assert, sync-to-clk deassert expected upstream) forces:
  - occupancy=0, out_valid=0, in_ready=all ones
  - amo_block=0, all_empty=1
  - pointers=0
- Reset mid-operation discards all buffered requests without emitting them.
- out_valid must stay asserted with stable payload until dequeued; this is the valid/ready contract downstream and is checked by assertion.

## Structure
- Shared package vx_dcache_req_pkg:
  - typedef dcache_req_t packed struct {rw, op_mod, is_amo, byteen, addr, data, tag}, parametrised through localparam widths matching the cache defines.
  - Function to compute the occupancy width.
- Sub-module vx_dcache_req_lane_fifo: one lane holding the FIFO, count, pointers and AMO block. The top generates NUM_REQS instances and ANDs their empty flags into all_empty.

## Test plan
- Single lane, DEPTH=2: enqueue addr 0x10 at cycle 1 with out_ready=0 -> out_valid=1 at cycle 2 and occupancy=1. Enqueue 0x14 -> in_ready=0, occupancy=2. Raise out_ready -> 0x10 then 0x14 emitted in order.
- Streaming: in_valid and out_ready held high for 100 cycles on all 4 lanes -> 100 requests per lane in order, tags intact, occupancy never exceeds 1.
- AMO: lane 0 enqueues a store, then an AMO tag 0x5A, then a load -> the load is refused (in_ready=0) until the cycle after tag 0x5A dequeues. Lane 1 keeps accepting throughout.
- Independence: out_ready[2]=0 for 20 cycles -> lane 2 fills to DEPTH and drops in_ready; the other lanes keep flowing; all_empty=0.
- Reset: assert reset_n=0 mid-burst with occupancy=2 -> outputs immediately at reset values, all_empty=1, and no stale request emitted after release.
- AMO_SERIALIZE=0, DEPTH=4: back-to-back AMOs are accepted without stall and occupancy reaches 4.
